sevenseg_muxn_ca: RTL and testbench

Parametrised N-digit multiplexed driver for common-anode seven-segment displays. It decodes full hexadecimal (0–F), drives per-digit decimal points and blanking, and dims the display by PWM. Each digit slot begins with a dead-time cycle for anti-ghosting. All digit values are captured once per frame, so the display never tears when a value changes mid-frame. It sits between the counter/datapath logic and the board display pins, replacing the fixed 4-digit BCD multiplexer.

---
 rtl/sevenseg_muxn_ca.sv | 153 +++++++++++++++
 tb/tb_sevenseg_muxn_ca.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_muxn_ca.sv
// sevenseg_muxn_ca: N-digit multiplexed common-anode 7-segment driver with hex decode, PWM dimming and frame-coherent input capture.
// Optional build macro: SEVENSEG_LZB_EN enables leading-zero blanking. Revision: 1.0
`default_nettype none

module sevenseg_muxn_ca #(
    parameter int F_CLK_HZ   = 50000000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_in_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic [BRIGHT_W-1:0]       brightness_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_tick_o
);

    localparam int TICKS = F_CLK_HZ / REFRESH_HZ;
    localparam int DIV_W = $clog2(TICKS);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int ON_W  = BRIGHT_W + DIV_W;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q;
    logic                    wrap_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q;

    logic                    div_wrap, sel_wrap, frame_wrap;
    logic [ON_W-1:0]         bright_ext, on_prod, on_len;
    logic                    in_window, slot_blank, lit;
    logic [3:0]              nib_sel;
    logic [NUM_DIGITS-1:0]   eff_blank;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b0000011;
            4'hC:    code = 7'b1000110;
            4'hD:    code = 7'b0100001;
            4'hE:    code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

    always_comb begin
        div_wrap   = (div_q == DIV_W'(TICKS - 1));
        sel_wrap   = (sel_q == SEL_W'(NUM_DIGITS - 1));
        frame_wrap = div_wrap && sel_wrap;
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        sel_d      = sel_q;
        if (div_wrap) begin
            sel_d = sel_wrap ? '0 : sel_q + SEL_W'(1);
        end
    end

    // Full-width product so the shift sees every bit of (brightness+1)*(TICKS-1).
    always_comb begin
        bright_ext = {{DIV_W{1'b0}}, brightness_i} + ON_W'(1);
        on_prod    = bright_ext * ON_W'(TICKS - 1);
        on_len     = on_prod >> BRIGHT_W;
        in_window  = (div_q != '0) && ({{BRIGHT_W{1'b0}}, div_q} <= on_len);
    end

`ifdef SEVENSEG_LZB_EN
    logic zero_run;
    always_comb begin
        eff_blank = sh_blank_q;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (sh_digits_q[4*k +: 4] == 4'h0) && !sh_dp_q[k];
            if (zero_run) begin
                eff_blank[k] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        eff_blank = sh_blank_q;
    end
`endif

    // seg holds for the whole slot so it only moves while the anodes are all off.
    always_comb begin
        nib_sel    = sh_digits_q[{sel_q, 2'b00} +: 4];
        slot_blank = eff_blank[sel_q];
        lit        = in_window && !slot_blank;
        an_d       = '1;
        if (lit) begin
            an_d[sel_q] = 1'b0;
        end
        seg_d = slot_blank ? 7'h7F : f_decode(nib_sel);
        dp_d  = lit ? ~sh_dp_q[sel_q] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            sel_q        <= '0;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            wrap_q       <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            sel_q        <= sel_d;
            wrap_q       <= frame_wrap;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= wrap_q;
            if (frame_wrap) begin
                sh_digits_q <= digits_i;
                sh_dp_q     <= dp_in_i;
                sh_blank_q  <= blank_i;
            end
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_muxn_ca.sv
// tb_sevenseg_muxn_ca: directed self-checking bench for sevenseg_muxn_ca (4- and 6-digit instances, TICKS=16).
// Revision: 1.0
`default_nettype none

module tb_sevenseg_muxn_ca;

    localparam int F_CLK = 1600;
    localparam int R_HZ  = 100;
    localparam int BW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits4 = 16'h12AF;
    logic [3:0]  dp4 = 4'b0000;
    logic [3:0]  blank4 = 4'b0000;
    logic [23:0] digits6 = 24'h543210;
    logic [5:0]  dp6 = 6'b000001;
    logic [5:0]  blank6 = 6'b000100;
    logic [2:0]  bright = 3'd7;

    logic [6:0]  seg4, seg6;
    logic        dpo4, dpo6, ft4, ft6;
    logic [3:0]  an4;
    logic [5:0]  an6;

    logic        use6 = 1'b0;
    logic [7:0]  obs_an;
    logic [6:0]  obs_seg;
    logic        obs_dp, obs_ft;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sevenseg_muxn_ca #(.F_CLK_HZ(F_CLK), .REFRESH_HZ(R_HZ), .NUM_DIGITS(4), .BRIGHT_W(BW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .digits_i(digits4), .dp_in_i(dp4), .blank_i(blank4),
        .brightness_i(bright), .seg_o(seg4), .dp_o(dpo4), .an_o(an4), .frame_tick_o(ft4)
    );

    sevenseg_muxn_ca #(.F_CLK_HZ(F_CLK), .REFRESH_HZ(R_HZ), .NUM_DIGITS(6), .BRIGHT_W(BW)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .digits_i(digits6), .dp_in_i(dp6), .blank_i(blank6),
        .brightness_i(bright), .seg_o(seg6), .dp_o(dpo6), .an_o(an6), .frame_tick_o(ft6)
    );

    always_comb begin
        if (use6) begin
            obs_an = {2'b11, an6}; obs_seg = seg6; obs_dp = dpo6; obs_ft = ft6;
        end else begin
            obs_an = {4'hF, an4};  obs_seg = seg4; obs_dp = dpo4; obs_ft = ft4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ft();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (obs_ft !== 1'b1 && k < 200);
        check("sync", {31'b0, obs_ft}, 32'd1);
    endtask

    // Release happens between edges; dark for 64 samples, frame_tick on the 65th.
    task automatic reset_sync(input string tag);
        int   k;
        logic dark;
        k = 0;
        dark = 1'b1;
        do begin
            step();
            k++;
            if (obs_ft !== 1'b1 && (obs_an !== 8'hFF || obs_seg !== 7'h7F || obs_dp !== 1'b1)) dark = 1'b0;
        end while (obs_ft !== 1'b1 && k < 200);
        check({tag, " latency"}, k, 32'd65);
        check({tag, " dark"}, {31'b0, dark}, 32'd1);
    endtask

    // Starts on the frame_tick sample, checks every cycle of one frame, ends on the next frame_tick.
    task automatic frame_check(input string tag, input int n, input int lit, input logic [55:0] codes,
                               input logic [7:0] blk, input logic [7:0] dpm,
                               input int chg_slot, input logic [15:0] chg_val);
        logic       exp_lit, exp_dp, exp_ft;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        int         lit_cnt;
        for (int s = 0; s < n; s++) begin
            lit_cnt = 0;
            for (int d = 0; d < 16; d++) begin
                if (!(s == 0 && d == 0)) step();
                exp_lit = !blk[s] && d >= 1 && d <= lit;
                exp_an  = exp_lit ? ~(8'b1 << s) : 8'hFF;
                exp_seg = blk[s] ? 7'h7F : codes[s*7 +: 7];
                exp_dp  = exp_lit ? ~dpm[s] : 1'b1;
                exp_ft  = (s == 0 && d == 0);
                check($sformatf("%s s%0d c%0d {an,seg,dp,ft}", tag, s, d),
                      {15'b0, obs_an, obs_seg, obs_dp, obs_ft},
                      {15'b0, exp_an, exp_seg, exp_dp, exp_ft});
                if (obs_an !== 8'hFF) lit_cnt++;
                if (s == chg_slot && d == 5) digits4 = chg_val;
            end
            check($sformatf("%s s%0d lit cycles", tag, s), lit_cnt, blk[s] ? 32'd0 : lit);
        end
        step();
        check({tag, " frame period"}, {31'b0, obs_ft}, 32'd1);
    endtask

    initial begin
        repeat (3) step();
        check("reset an",  {24'b0, obs_an},  32'hFF);
        check("reset seg", {25'b0, obs_seg}, 32'h7F);
        check("reset dp",  {31'b0, obs_dp},  32'd1);
        check("reset ft",  {31'b0, obs_ft},  32'd0);
        rst_n = 1'b1;
        reset_sync("startup");

        frame_check("b7 12AF", 4, 15, {28'hFFFFFFF, 7'h79, 7'h24, 7'h08, 7'h0E}, 8'h00, 8'h00, -1, 16'h0);

        bright = 3'd0;
        frame_check("b0", 4, 1, {28'hFFFFFFF, 7'h79, 7'h24, 7'h08, 7'h0E}, 8'h00, 8'h00, -1, 16'h0);
        bright = 3'd3;
        frame_check("b3", 4, 7, {28'hFFFFFFF, 7'h79, 7'h24, 7'h08, 7'h0E}, 8'h00, 8'h00, -1, 16'h0);

        bright = 3'd7;
        digits4 = 16'h1111;
        wait_ft();
        frame_check("coh old", 4, 15, {28'hFFFFFFF, 7'h79, 7'h79, 7'h79, 7'h79}, 8'h00, 8'h00, 2, 16'h2222);
        frame_check("coh new", 4, 15, {28'hFFFFFFF, 7'h24, 7'h24, 7'h24, 7'h24}, 8'h00, 8'h00, -1, 16'h0);

        digits4 = 16'h0040;
        wait_ft();
`ifdef SEVENSEG_LZB_EN
        frame_check("lzb", 4, 15, {28'hFFFFFFF, 7'h40, 7'h40, 7'h19, 7'h40}, 8'b1100, 8'h00, -1, 16'h0);
`else
        frame_check("lzb", 4, 15, {28'hFFFFFFF, 7'h40, 7'h40, 7'h19, 7'h40}, 8'h00, 8'h00, -1, 16'h0);
`endif
        dp4 = 4'b1000;
        wait_ft();
        frame_check("lzb dp", 4, 15, {28'hFFFFFFF, 7'h40, 7'h40, 7'h19, 7'h40}, 8'h00, 8'b1000, -1, 16'h0);

        repeat (37) step();
        #2 rst_n = 1'b0;
        #1;
        check("async rst an",  {24'b0, obs_an},  32'hFF);
        check("async rst seg", {25'b0, obs_seg}, 32'h7F);
        check("async rst dp",  {31'b0, obs_dp},  32'd1);
        check("async rst ft",  {31'b0, obs_ft},  32'd0);
        step();
        step();
        rst_n = 1'b1;
        reset_sync("midrst");
        frame_check("after rst", 4, 15, {28'hFFFFFFF, 7'h40, 7'h40, 7'h19, 7'h40}, 8'h00, 8'b1000, -1, 16'h0);

        use6 = 1'b1;
        wait_ft();
        wait_ft();
        frame_check("n6 blank dp", 6, 15, {14'h3FFF, 7'h12, 7'h19, 7'h30, 7'h7F, 7'h79, 7'h40},
                    8'b000100, 8'b000001, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
